// File: rtl/mem_pkg.sv
// Shared encodings for the data memory bank: access sizes, bank state and
// the size-to-alignment helper.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } memState_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] alignMask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'b000;
            SIZE_HALF: return 3'b001;
            SIZE_WORD: return 3'b011;
            default:   return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory bank: store byte enables and merge
// into the old word, and load shift-down with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                       size,
    input  logic                             isSigned,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  laneOffset,
    input  logic [DATA_WIDTH-1:0]            storeData,
    input  logic [DATA_WIDTH-1:0]            oldWord,
    output logic [DATA_WIDTH/8-1:0]          byteEnable,
    output logic [DATA_WIDTH-1:0]            mergedWord,
    output logic [DATA_WIDTH-1:0]            loadData
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int BIT_IDXW = $clog2(DATA_WIDTH);

    logic [3:0]            byteCount;
    logic [BIT_IDXW-1:0]   topBit;
    logic [DATA_WIDTH-1:0] shiftedStore;
    logic [DATA_WIDTH-1:0] shiftedLoad;
    logic                  signBit;

    assign shiftedStore = storeData << {laneOffset, 3'b000};
    assign shiftedLoad  = oldWord >> {laneOffset, 3'b000};
    assign signBit      = isSigned & shiftedLoad[topBit];

    // Access width in bytes and the index of the loaded value's sign bit.
    // NOTE: every output of an always_comb is assigned on every path so no latch is inferred.
    always_comb begin
        case (size)
            SIZE_BYTE: begin byteCount = 4'd1; topBit = BIT_IDXW'(7);  end
            SIZE_HALF: begin byteCount = 4'd2; topBit = BIT_IDXW'(15); end
            SIZE_WORD: begin byteCount = 4'd4; topBit = BIT_IDXW'(31); end
            default:   begin byteCount = 4'd8; topBit = BIT_IDXW'(DATA_WIDTH - 1); end
        endcase
    end

    // Enable the lanes covered by the access and merge store bytes into them.
    always_comb begin
        for (int b = 0; b < BYTES; b++) begin
            byteEnable[b] = (b >= int'(laneOffset)) &&
                            (b < int'(laneOffset) + int'(byteCount));
            mergedWord[b*8 +: 8] = byteEnable[b] ? shiftedStore[b*8 +: 8]
                                                 : oldWord[b*8 +: 8];
        end
    end

    // Keep the bits of the access, replicate the sign (or zero) above them.
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            loadData[i] = (i <= int'(topBit)) ? shiftedLoad[i] : signBit;
        end
    end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressed MEM-stage data memory with sized loads/stores, a one-cycle
// registered request/response handshake, fault reporting and a post-reset
// zero-fill sequence.
module data_memory_bank
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    memState_t             state;
    logic [IDX_W-1:0]      clrIdx;
    logic                  readyQ;

    logic                  accept;
    logic                  sizeFault;
    logic                  alignFault;
    logic                  rangeFault;
    logic                  fault;
    logic [IDX_W-1:0]      wordIdx;
    logic [OFF_W-1:0]      laneOffset;
    logic [DATA_WIDTH-1:0] oldWord;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [DATA_WIDTH-1:0] loadData;
    logic [BYTES-1:0]      byteEnable;

    assign req_ready  = readyQ;
    assign accept     = req_valid && readyQ;

    assign wordIdx    = req_addr[OFF_W +: IDX_W];
    assign laneOffset = req_addr[OFF_W-1:0];
    assign oldWord    = mem[wordIdx];

    // A doubleword only exists in the 64-bit build; any fault blocks the write.
    assign sizeFault  = (req_size == SIZE_DWORD) && (DATA_WIDTH == 32);
    assign alignFault = |(req_addr[2:0] & alignMask(req_size));
    assign rangeFault = {1'b0, req_addr} >= MEM_BYTES;
    assign fault      = sizeFault || alignFault || rangeFault;

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .size       (req_size),
        .isSigned   (req_signed),
        .laneOffset (laneOffset),
        .storeData  (req_wdata),
        .oldWord    (oldWord),
        .byteEnable (byteEnable),
        .mergedWord (mergedWord),
        .loadData   (loadData)
    );

    // Bank state: walk clrIdx over every word after reset, then accept requests.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clrIdx <= '0;
            readyQ <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clrIdx == IDX_W'(DEPTH - 1)) begin
                        state  <= READY;
                        readyQ <= 1'b1;
                    end else begin
                        clrIdx <= clrIdx + 1'b1;
                    end
                end
                READY:   readyQ <= 1'b1;
                default: state  <= READY;
            endcase
        end
    end

    // Storage writes: zero-fill during CLEAR, lane-masked stores when READY.
    // NOTE: the array has no reset branch; zeroing is done word by word by the CLEAR walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clrIdx] <= '0;
            end else if (accept && req_write && !fault) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byteEnable[b]) begin
                        mem[wordIdx][b*8 +: 8] <= mergedWord[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered response, one cycle after acceptance, data only for good loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept;
            rsp_error <= accept && fault;
            rsp_rdata <= (accept && !req_write && !fault) ? loadData : '0;
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank (32-bit words, 128 words).
module tb_data_memory_bank;
    import mem_pkg::*;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [33:0] exp;
        string       name;
    } vec_t;

    localparam logic [33:0] ERR_RSP = {2'b11, 32'h0};

    always #5 clk = ~clk;

    data_memory_bank #(
        .DATA_WIDTH     (32),
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (32),
        .CLEAR_ON_RESET (1),
        .INIT_FILE      ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    function automatic logic [33:0] okRsp(input logic [31:0] d);
        return {2'b10, d};
    endfunction

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [33:0] exp, input string name);
        vec_t v;
        v.w = w; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
        v.exp = exp; v.name = name;
        return v;
    endfunction

    // One request, returns {rsp_valid, rsp_error, rsp_rdata} of the following cycle.
    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [33:0] rsp);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp = {rsp_valid, rsp_error, rsp_rdata};
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Counts edges until req_ready rises (bounded); notes any response seen meanwhile.
    task automatic waitReady(output int cnt, output bit sawRsp);
        cnt = 0;
        sawRsp = 1'b0;
        while (!req_ready && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
            if (rsp_valid) sawRsp = 1'b1;
        end
    endtask

    task automatic test_reset();
        int  cnt;
        bit  saw;
        @(posedge clk);
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h, expected %h",
                     {req_ready, rsp_valid, rsp_error, rsp_rdata}, 35'd0);
        end
        reset = 1'b0;
        waitReady(cnt, saw);
        vectors++;
        if (cnt !== DEPTH) begin
            miscompares++;
            $display("FAIL clear_duration: got %0d edges, expected %0d", cnt, DEPTH);
        end
    endtask

    task automatic test_clear_contents();
        logic [33:0] r;
        for (int i = 0; i < 16; i++) begin
            doReq(1'b0, SIZE_WORD, 1'b0, 32'(i * 4), '0, r);
            vectors++;
            if (r !== okRsp(32'h0)) begin
                miscompares++;
                $display("FAIL clear_word_%0d: got %h, expected %h", i, r, okRsp(32'h0));
            end
        end
    endtask

    task automatic test_subword();
        vec_t        tbl[$];
        logic [33:0] r;
        tbl.push_back(mk(1, SIZE_WORD, 0, 32'h10, 32'h80FF7F01, okRsp(32'h0),        "sw_10"));
        tbl.push_back(mk(0, SIZE_BYTE, 1, 32'h10, 32'h0,        okRsp(32'h00000001), "lb_10"));
        tbl.push_back(mk(0, SIZE_BYTE, 1, 32'h13, 32'h0,        okRsp(32'hFFFFFF80), "lb_13"));
        tbl.push_back(mk(0, SIZE_BYTE, 0, 32'h13, 32'h0,        okRsp(32'h00000080), "lbu_13"));
        tbl.push_back(mk(0, SIZE_HALF, 1, 32'h12, 32'h0,        okRsp(32'hFFFF80FF), "lh_12"));
        tbl.push_back(mk(0, SIZE_HALF, 0, 32'h12, 32'h0,        okRsp(32'h000080FF), "lhu_12"));
        tbl.push_back(mk(0, SIZE_BYTE, 1, 32'h11, 32'h0,        okRsp(32'h0000007F), "lb_11"));
        tbl.push_back(mk(0, SIZE_BYTE, 0, 32'h12, 32'h0,        okRsp(32'h000000FF), "lbu_12"));
        tbl.push_back(mk(0, SIZE_HALF, 1, 32'h10, 32'h0,        okRsp(32'h00007F01), "lh_10"));
        tbl.push_back(mk(0, SIZE_WORD, 1, 32'h10, 32'h0,        okRsp(32'h80FF7F01), "lw_10"));
        foreach (tbl[i]) begin
            doReq(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, r);
            vectors++;
            if (r !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", tbl[i].name, r, tbl[i].exp);
            end
        end
    endtask

    task automatic test_partial_write();
        vec_t        tbl[$];
        logic [33:0] r;
        tbl.push_back(mk(1, SIZE_WORD, 0, 32'h20, 32'h11223344, okRsp(32'h0),        "sw_20"));
        tbl.push_back(mk(1, SIZE_BYTE, 0, 32'h21, 32'h000000AA, okRsp(32'h0),        "sb_21"));
        tbl.push_back(mk(0, SIZE_WORD, 0, 32'h20, 32'h0,        okRsp(32'h1122AA44), "lw_after_sb"));
        tbl.push_back(mk(1, SIZE_HALF, 0, 32'h22, 32'h00005566, okRsp(32'h0),        "sh_22"));
        tbl.push_back(mk(0, SIZE_WORD, 0, 32'h20, 32'h0,        okRsp(32'h5566AA44), "lw_after_sh"));
        tbl.push_back(mk(1, SIZE_BYTE, 0, 32'h20, 32'hFFFFFFBB, okRsp(32'h0),        "sb_20_wide"));
        tbl.push_back(mk(0, SIZE_WORD, 0, 32'h20, 32'h0,        okRsp(32'h5566AABB), "lw_after_sb_wide"));
        tbl.push_back(mk(0, SIZE_HALF, 1, 32'h20, 32'h0,        okRsp(32'hFFFFAABB), "lh_20"));
        foreach (tbl[i]) begin
            doReq(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, r);
            vectors++;
            if (r !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", tbl[i].name, r, tbl[i].exp);
            end
        end
    endtask

    task automatic test_faults();
        vec_t        tbl[$];
        logic [33:0] r;
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h22,  32'h0,        ERR_RSP,             "lw_misaligned"));
        tbl.push_back(mk(0, SIZE_HALF,  1, 32'h21,  32'h0,        ERR_RSP,             "lh_misaligned"));
        tbl.push_back(mk(1, SIZE_WORD,  0, 32'h22,  32'h12345678, ERR_RSP,             "sw_misaligned"));
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h20,  32'h0,        okRsp(32'h5566AABB), "lw_unchanged_1"));
        tbl.push_back(mk(1, SIZE_HALF,  0, 32'h201, 32'h0000BEEF, ERR_RSP,             "sh_201"));
        tbl.push_back(mk(1, SIZE_WORD,  0, 32'h200, 32'h12345678, ERR_RSP,             "sw_range"));
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h200, 32'h0,        ERR_RSP,             "lw_range"));
        tbl.push_back(mk(0, SIZE_BYTE,  0, 32'h200, 32'h0,        ERR_RSP,             "lbu_range"));
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h0,   32'h0,        okRsp(32'h0),        "lw_no_alias"));
        tbl.push_back(mk(0, SIZE_DWORD, 0, 32'h20,  32'h0,        ERR_RSP,             "ld_size3"));
        tbl.push_back(mk(1, SIZE_DWORD, 0, 32'h20,  32'hFFFFFFFF, ERR_RSP,             "sd_size3"));
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h20,  32'h0,        okRsp(32'h5566AABB), "lw_unchanged_2"));
        tbl.push_back(mk(1, SIZE_WORD,  0, 32'h1FC, 32'hCAFEF00D, okRsp(32'h0),        "sw_last"));
        tbl.push_back(mk(0, SIZE_WORD,  0, 32'h1FC, 32'h0,        okRsp(32'hCAFEF00D), "lw_last"));
        tbl.push_back(mk(0, SIZE_BYTE,  0, 32'h1FF, 32'h0,        okRsp(32'h000000CA), "lbu_last"));
        foreach (tbl[i]) begin
            doReq(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wdata, r);
            vectors++;
            if (r !== tbl[i].exp) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h", tbl[i].name, r, tbl[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] r1, r2, r3;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_signed = 1'b0;
        req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        r1 = {rsp_valid, rsp_error, rsp_rdata};
        req_write = 1'b0; req_addr = 32'h8; req_wdata = '0;
        @(posedge clk);
        #1;
        r2 = {rsp_valid, rsp_error, rsp_rdata};
        req_size = SIZE_BYTE; req_addr = 32'hB;
        @(posedge clk);
        #1;
        r3 = {rsp_valid, rsp_error, rsp_rdata};
        req_valid = 1'b0;
        vectors++;
        if (r1 !== okRsp(32'h0)) begin
            miscompares++;
            $display("FAIL b2b_store: got %h, expected %h", r1, okRsp(32'h0));
        end
        vectors++;
        if (r2 !== okRsp(32'hDEADBEEF)) begin
            miscompares++;
            $display("FAIL b2b_load: got %h, expected %h", r2, okRsp(32'hDEADBEEF));
        end
        vectors++;
        if (r3 !== okRsp(32'h000000DE)) begin
            miscompares++;
            $display("FAIL b2b_third: got %h, expected %h", r3, okRsp(32'h000000DE));
        end
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [33:0] r;
        int          cnt;
        bit          saw;
        doReq(1'b1, SIZE_WORD, 1'b0, 32'h190, 32'hA5A5A5A5, r);
        pulseReset();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (dut.clrIdx !== 7'd5) begin
            miscompares++;
            $display("FAIL midclear_idx5: got %0d, expected 5", dut.clrIdx);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if ({dut.clrIdx, req_ready} !== 8'd0) begin
            miscompares++;
            $display("FAIL midclear_restart: got idx=%0d ready=%b, expected idx=0 ready=0",
                     dut.clrIdx, req_ready);
        end
        req_valid = 1'b1; req_write = 1'b0; req_size = SIZE_WORD; req_addr = 32'h0;
        waitReady(cnt, saw);
        req_valid = 1'b0;
        vectors++;
        if (cnt !== DEPTH) begin
            miscompares++;
            $display("FAIL midclear_duration: got %0d edges, expected %0d", cnt, DEPTH);
        end
        vectors++;
        if (saw !== 1'b0) begin
            miscompares++;
            $display("FAIL midclear_no_rsp: got response during clear, expected none");
        end
        doReq(1'b0, SIZE_WORD, 1'b0, 32'h190, '0, r);
        vectors++;
        if (r !== okRsp(32'h0)) begin
            miscompares++;
            $display("FAIL midclear_zeroed: got %h, expected %h", r, okRsp(32'h0));
        end
    endtask

    task automatic test_reset_wins();
        int cnt;
        bit saw;
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD;
        req_addr = 32'h30; req_wdata = 32'h77777777;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        vectors++;
        if ({rsp_valid, req_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_wins: got rsp_valid=%b ready=%b, expected 0 0",
                     rsp_valid, req_ready);
        end
        waitReady(cnt, saw);
        vectors++;
        if (cnt !== DEPTH) begin
            miscompares++;
            $display("FAIL reset_wins_duration: got %0d edges, expected %0d", cnt, DEPTH);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_contents();
        test_subword();
        test_partial_write();
        test_faults();
        test_back_to_back();
        test_reset_mid_clear();
        test_reset_wins();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
